// File: rtl/game_pkg.sv
// Shared playfield constants, state encoding and wall bundle.
// Used by the scroller, the collision checker and the renderer.
package game_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int WALL_W   = 16;
  localparam int GAP_H    = 40;
  localparam int BIRD_X   = 40;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FROZEN
  } state_t;

  typedef struct packed {
    logic [X_W-1:0] xleft;
    logic [X_W-1:0] xright;
    logic [Y_W-1:0] topy;
    logic [Y_W-1:0] bottomy;
  } wall_t;

  function automatic wall_t init_wall(input int gap_min);
    wall_t w;
    w.xleft   = X_W'(SCREEN_W - WALL_W);
    w.xright  = X_W'(SCREEN_W - 1);
    w.topy    = Y_W'(gap_min);
    w.bottomy = Y_W'(gap_min + GAP_H - 1);
    return w;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, taps 8/6/5/4 (period 255).
// Shifts left every clock; seed is loaded on reset only.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] q
);

  logic fb;

  assign fb = q[7] ^ q[5] ^ q[4] ^ q[3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= SEED;
    end else begin
      q <= {q[6:0], fb};
    end
  end

endmodule

// File: rtl/pipe_scroller.sv
// Scrolls one wall leftward per frame tick, respawns it with a random gap,
// freezes on collision and scores when the wall clears the bird column.
module pipe_scroller
  import game_pkg::*;
#(
  parameter int         GAP_MIN   = 8,
  parameter int         RAND_BITS = 6,
  parameter int         SPEED     = 1,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           frame_tick,
  input  logic           start,
  input  logic           restart,
  input  logic           touched,
  output logic [X_W-1:0] wall_xleft,
  output logic [X_W-1:0] wall_xright,
  output logic [Y_W-1:0] wall_topy,
  output logic [Y_W-1:0] wall_bottomy,
  output logic           coords_valid,
  output logic           running,
  output logic           score_pulse,
  output logic [7:0]     score
);

  if (GAP_MIN + 2**RAND_BITS - 1 + GAP_H > SCREEN_H - 1) begin : g_gap_chk
    $error("gap range exceeds playfield height");
  end
  if (SCREEN_W - 1 >= 2**X_W) begin : g_xw_chk
    $error("SCREEN_W-1 does not fit in X_W bits");
  end
  if (SCREEN_H - 1 >= 2**Y_W) begin : g_yw_chk
    $error("SCREEN_H-1 does not fit in Y_W bits");
  end

  localparam wall_t WALL_INIT = init_wall(GAP_MIN);

  state_t     state_q;
  wall_t      wall_q;
  logic       valid_q;
  logic       run_q;
  logic       pulse_q;
  logic [7:0] score_q;
  logic [7:0] lfsr;

  lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr)
  );

  logic [7:0] rnd;
  logic       can_move;
  logic       passed;
  wall_t      moved;
  wall_t      spawn;

  always_comb begin
    rnd      = lfsr & 8'(2**RAND_BITS - 1);
    can_move = wall_q.xleft >= X_W'(SPEED);

    moved        = wall_q;
    moved.xleft  = wall_q.xleft - X_W'(SPEED);
    moved.xright = wall_q.xright - X_W'(SPEED);

    // gap is drawn from the LFSR value present at the respawn edge
    spawn         = WALL_INIT;
    spawn.topy    = Y_W'(GAP_MIN) + Y_W'(rnd);
    spawn.bottomy = spawn.topy + Y_W'(GAP_H - 1);

    passed = (wall_q.xright >= X_W'(BIRD_X))
          && (moved.xright < X_W'(BIRD_X));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wall_q  <= WALL_INIT;
      valid_q <= 1'b0;
      run_q   <= 1'b0;
      pulse_q <= 1'b0;
      score_q <= 8'd0;
    end else begin
      pulse_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            valid_q <= 1'b1;
            run_q   <= 1'b1;
          end
        end
        RUN: begin
          if (touched) begin
            state_q <= FROZEN;
            run_q   <= 1'b0;
          end else if (frame_tick) begin
            if (can_move) begin
              wall_q <= moved;
              if (passed) begin
                pulse_q <= 1'b1;
                score_q <= score_q + 8'(score_q != 8'hFF);
              end
            end else begin
              wall_q <= spawn;
            end
          end
        end
        FROZEN: begin
          if (restart) begin
            state_q <= IDLE;
            wall_q  <= WALL_INIT;
            valid_q <= 1'b0;
            score_q <= 8'd0;
          end
        end
        default: begin
          state_q <= IDLE;
          wall_q  <= WALL_INIT;
          valid_q <= 1'b0;
          run_q   <= 1'b0;
        end
      endcase
    end
  end

  assign wall_xleft   = wall_q.xleft;
  assign wall_xright  = wall_q.xright;
  assign wall_topy    = wall_q.topy;
  assign wall_bottomy = wall_q.bottomy;
  assign coords_valid = valid_q;
  assign running      = run_q;
  assign score_pulse  = pulse_q;
  assign score        = score_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// Scoreboard bench for pipe_scroller: an integer reference model pushes the
// expected outputs every clock; a negedge monitor pops and compares.
module tb_pipe_scroller;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       restart = 1'b0;
  logic       touched = 1'b0;
  logic [7:0] wall_xleft;
  logic [7:0] wall_xright;
  logic [6:0] wall_topy;
  logic [6:0] wall_bottomy;
  logic       coords_valid;
  logic       running;
  logic       score_pulse;
  logic [7:0] score;

  int checks = 0;
  int errors = 0;

  pipe_scroller dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .start        (start),
    .restart      (restart),
    .touched      (touched),
    .wall_xleft   (wall_xleft),
    .wall_xright  (wall_xright),
    .wall_topy    (wall_topy),
    .wall_bottomy (wall_bottomy),
    .coords_valid (coords_valid),
    .running      (running),
    .score_pulse  (score_pulse),
    .score        (score)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] xl;
    logic [7:0] xr;
    logic [6:0] ty;
    logic [6:0] by;
    logic       valid;
    logic       run;
    logic       pulse;
    logic [7:0] score;
    logic [7:0] lfsr;
  } obs_t;

  obs_t exp_q[$];

  // reference model: 0 idle, 1 run, 2 frozen
  int         m_st;
  int         m_x;
  int         m_top;
  int         m_score;
  bit         m_pulse;
  logic [7:0] m_lfsr;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  task automatic model_init();
    m_st    = 0;
    m_x     = 144;
    m_top   = 8;
    m_score = 0;
    m_pulse = 0;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_init();
      m_lfsr = 8'hA5;
      exp_q.delete();
    end else begin
      obs_t e;
      m_pulse = 0;
      case (m_st)
        0: if (start) m_st = 1;
        1: begin
          if (touched) begin
            m_st = 2;
          end else if (frame_tick) begin
            if (m_x >= 1) begin
              if (m_x + 15 >= 40 && m_x + 14 < 40) begin
                m_pulse = 1;
                if (m_score < 255) m_score++;
              end
              m_x = m_x - 1;
            end else begin
              m_x   = 144;
              m_top = 8 + (int'(m_lfsr) % 64);
            end
          end
        end
        default: if (restart) model_init();
      endcase
      m_lfsr  = lfsr_step(m_lfsr);
      e.xl    = 8'(m_x);
      e.xr    = 8'(m_x + 15);
      e.ty    = 7'(m_top);
      e.by    = 7'(m_top + 39);
      e.valid = (m_st != 0);
      e.run   = (m_st == 1);
      e.pulse = m_pulse;
      e.score = 8'(m_score);
      e.lfsr  = m_lfsr;
      exp_q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (!reset && exp_q.size() > 0) begin
      obs_t e;
      obs_t a;
      e = exp_q.pop_front();
      a = '{wall_xleft, wall_xright, wall_topy, wall_bottomy,
            coords_valid, running, score_pulse, score, dut.u_lfsr.q};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_obs t=%0t got x=%0d/%0d y=%0d/%0d v=%b r=%b p=%b s=%0d l=%h exp x=%0d/%0d y=%0d/%0d v=%b r=%b p=%b s=%0d l=%h",
          $time, a.xl, a.xr, a.ty, a.by, a.valid, a.run, a.pulse, a.score, a.lfsr,
          e.xl, e.xr, e.ty, e.by, e.valid, e.run, e.pulse, e.score, e.lfsr);
      end
      if (coords_valid) begin
        checks++;
        if (wall_topy < 8 || wall_topy > 71 || wall_bottomy > 110) begin
          errors++;
          $display("FAIL gap_range got top=%0d bot=%0d exp top 8..71 bot<=110",
            wall_topy, wall_bottomy);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    cycle();
  endtask

  task automatic chk_init(input string tag);
    chk({tag, "_xl"}, int'(wall_xleft), 144);
    chk({tag, "_xr"}, int'(wall_xright), 159);
    chk({tag, "_ty"}, int'(wall_topy), 8);
    chk({tag, "_by"}, int'(wall_bottomy), 47);
    chk({tag, "_score"}, int'(score), 0);
    chk({tag, "_valid"}, int'(coords_valid), 0);
    chk({tag, "_run"}, int'(running), 0);
  endtask

  initial begin
    int pulses;
    bit zero_seen;

    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    chk_init("reset");

    // LFSR period from the seed
    zero_seen = 0;
    for (int i = 0; i < 255; i++) begin
      cycle();
      if (dut.u_lfsr.q == 8'h00) zero_seen = 1;
    end
    chk("lfsr_zero", int'(zero_seen), 0);
    chk("lfsr_period", int'(dut.u_lfsr.q), 8'hA5);

    // reset in the middle of a run
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 44; i++) tick();
    chk("mid_xl", int'(wall_xleft), 100);
    #2 reset = 1'b1;
    #1;
    chk_init("async");
    chk("async_state", int'(dut.state_q == IDLE), 1);
    @(posedge clk);
    #2 reset = 1'b0;

    // pass the bird after 120 ticks
    start = 1'b1;
    cycle();
    start = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 120; i++) begin
      frame_tick = 1'b1;
      cycle();
      frame_tick = 1'b0;
      if (i < 120) begin
        pulses += int'(score_pulse);
      end else begin
        chk("pass_xr", int'(wall_xright), 39);
        chk("pass_pulse", int'(score_pulse), 1);
        chk("pass_score", int'(score), 1);
      end
      cycle();
      if (i == 120) chk("pulse_width", int'(score_pulse), 0);
    end
    chk("early_pulses", pulses, 0);

    for (int i = 121; i <= 144; i++) tick();
    chk("edge_xl", int'(wall_xleft), 0);
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    chk("respawn_xl", int'(wall_xleft), 144);
    chk("respawn_xr", int'(wall_xright), 159);
    chk("respawn_pulse", int'(score_pulse), 0);
    cycle();

    // start/restart ignored in RUN
    for (int i = 0; i < 10; i++) tick();
    start      = 1'b1;
    restart    = 1'b1;
    frame_tick = 1'b1;
    cycle();
    start      = 1'b0;
    restart    = 1'b0;
    frame_tick = 1'b0;
    chk("run_ign_xl", int'(wall_xleft), 133);
    chk("run_ign_run", int'(running), 1);
    cycle();

    // touched wins over a simultaneous tick
    touched    = 1'b1;
    frame_tick = 1'b1;
    cycle();
    touched    = 1'b0;
    frame_tick = 1'b0;
    chk("frz_xl", int'(wall_xleft), 133);
    chk("frz_run", int'(running), 0);
    chk("frz_valid", int'(coords_valid), 1);
    for (int i = 0; i < 5; i++) tick();
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("frz_hold_xl", int'(wall_xleft), 133);
    chk("frz_hold_score", int'(score), 1);
    chk("frz_start_run", int'(running), 0);
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    chk_init("restart");

    // random play without collisions
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      frame_tick = 1'($urandom_range(1));
      start      = ($urandom_range(9) == 0);
      restart    = ($urandom_range(9) == 0);
      cycle();
    end

    // 300 passes to saturate the score
    frame_tick = 1'b1;
    for (int i = 0; i < 300 * 145 + 200; i++) begin
      start   = ($urandom_range(15) == 0);
      restart = ($urandom_range(15) == 0);
      cycle();
    end
    frame_tick = 1'b0;
    start      = 1'b0;
    restart    = 1'b0;
    cycle();
    chk("score_sat", int'(score), 255);

    // random collision, then recovery
    frame_tick = 1'b1;
    repeat ($urandom_range(50, 5)) cycle();
    touched = 1'b1;
    cycle();
    touched = 1'b0;
    repeat (20) cycle();
    frame_tick = 1'b0;
    chk("late_frz_run", int'(running), 0);
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    cycle();
    chk_init("late_restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
